// File: rtl/fdc_disk_responder_if.sv
// Byte-wide request/ack port between the disk responder (master) and the
// backing store holding both drive images (slave).
interface fdc_disk_responder_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (output mem_addr, mem_rd, mem_wr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_addr, mem_rd, mem_wr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/fdc_disk_responder.sv
// Disk-side responder for the nec765 FDC: services seek / read ID / sector
// read / sector write requests against a byte-addressed two-drive image store.
module fdc_disk_responder #(
    parameter int         ADDR_W      = 24,
    parameter int         TRACKS      = 40,
    parameter int         SPT         = 9,
    parameter logic [7:0] SECTOR_BASE = 8'hC1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          disk_sr,
    output logic [31:0]          disk_cr,
    output logic [7:0]           disk_data_in,
    output logic                 disk_data_clkin,
    input  logic [7:0]           disk_data_out,
    output logic                 disk_data_clkout,
    input  logic [1:0]           img_mounted,
    input  logic [1:0]           img_wp,
    fdc_disk_responder_if.master mem
);
    typedef enum logic [3:0] {
        IDLE, SEEK, RID, RD_REQ, RD_PUSH, WR_GAP, WR_PULL, WR_REQ, DONE, WAIT_CLR
    } state_t;

    localparam logic [1:0] OP_RID = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_WR  = 2'd2;

    state_t            state_q, state_d;
    logic              drv_q, drv_d, h_q, h_d;
    logic [6:0]        c_q, c_d;
    logic [7:0]        r_q, r_d, rid_cnt_q, rid_cnt_d;
    logic [1:0]        op_q, op_d, seek_done_q, seek_done_d;
    logic [8:0]        byte_cnt_q, byte_cnt_d;
    logic              cr_err_q, cr_err_d, cr_done_q, cr_done_d;
    logic [7:0]        cr_h_q, cr_h_d, cr_r_q, cr_r_d;
    logic [7:0]        data_in_q, data_in_d, mem_wdata_q, mem_wdata_d;
    logic              clkin_q, clkin_d, clkout_q, clkout_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              req_any, req_seek, req_drv, req_err;
    logic [1:0]        req_op, held_req;
    logic              unused_sr_bits;

    assign unused_sr_bits = ^{disk_sr[31:26], disk_sr[19]};

    function automatic logic out_of_range(input logic [6:0] c, input logic [7:0] r);
        return (32'(c) >= TRACKS) || (r < SECTOR_BASE) || (32'(r) >= 32'(SECTOR_BASE) + SPT);
    endfunction

    function automatic logic [ADDR_W-1:0] sector_addr(input logic d, input logic [6:0] c,
                                                      input logic h, input logic [7:0] r,
                                                      input logic [8:0] cnt);
        logic [7:0]  roff;
        logic [31:0] idx;
        roff = r - SECTOR_BASE;
        idx  = ((32'(d) * TRACKS + 32'(c)) * 2 + 32'(h)) * SPT + 32'(roff);
        return ADDR_W'({idx[22:0], 9'd0} + 32'(cnt));
    endfunction

    // Request decode: seek > read ID > read > write; A wins within a field.
    always_comb begin
        req_seek = |disk_sr[25:24];
        req_any  = req_seek | (|disk_sr[23:22]) | (|disk_sr[21:20]) | (|disk_sr[18:17]);
        req_op   = OP_WR;
        req_drv  = ~disk_sr[20];
        if (req_seek) begin
            req_drv = ~disk_sr[24];
        end else if (|disk_sr[23:22]) begin
            req_op  = OP_RID;
            req_drv = ~disk_sr[22];
        end else if (|disk_sr[18:17]) begin
            req_op  = OP_RD;
            req_drv = ~disk_sr[17];
        end
        req_err = !img_mounted[req_drv]
                || (req_op != OP_RID && out_of_range(disk_sr[14:8], disk_sr[7:0]))
                || (req_op == OP_WR && img_wp[req_drv]);
        case (op_q)
            OP_RID:  held_req = disk_sr[23:22];
            OP_RD:   held_req = disk_sr[18:17];
            default: held_req = disk_sr[21:20];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        drv_d       = drv_q;
        c_d         = c_q;
        h_d         = h_q;
        r_d         = r_q;
        op_d        = op_q;
        rid_cnt_d   = rid_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        seek_done_d = seek_done_q;
        cr_err_d    = cr_err_q;
        cr_done_d   = cr_done_q;
        cr_h_d      = cr_h_q;
        cr_r_d      = cr_r_q;
        data_in_d   = data_in_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        clkin_d     = 1'b0;
        clkout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any && disk_cr[4:0] == 5'd0) begin
                    drv_d = req_drv;
                    c_d   = disk_sr[14:8];
                    h_d   = disk_sr[15];
                    r_d   = disk_sr[7:0];
                    op_d  = req_op;
                    if (req_seek) begin
                        seek_done_d[req_drv] = 1'b1;
                        cr_err_d = !img_mounted[req_drv] || (32'(disk_sr[14:8]) >= TRACKS);
                        state_d  = SEEK;
                    end else begin
                        cr_h_d = {7'd0, disk_sr[15]};
                        cr_r_d = disk_sr[7:0];
                        if (req_err) begin
                            cr_done_d = 1'b1;
                            cr_err_d  = 1'b1;
                            state_d   = WAIT_CLR;
                        end else if (req_op == OP_RID) begin
                            cr_done_d = 1'b1;
                            cr_r_d    = SECTOR_BASE + rid_cnt_q;
                            state_d   = RID;
                        end else if (req_op == OP_RD) begin
                            byte_cnt_d = 9'd0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = sector_addr(req_drv, disk_sr[14:8], disk_sr[15],
                                                     disk_sr[7:0], 9'd0);
                            state_d    = RD_REQ;
                        end else begin
                            byte_cnt_d = 9'd0;
                            state_d    = WR_GAP;
                        end
                    end
                end
            end
            SEEK: begin
                if (disk_sr[25:24] == 2'b00) begin
                    seek_done_d = 2'b00;
                    cr_err_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            RID: begin
                rid_cnt_d = (rid_cnt_q == 8'(SPT - 1)) ? 8'd0 : rid_cnt_q + 8'd1;
                state_d   = WAIT_CLR;
            end
            RD_REQ: begin
                if (mem.mem_ack) begin
                    mem_rd_d  = 1'b0;
                    data_in_d = mem.mem_rdata;
                    clkin_d   = 1'b1;
                    state_d   = RD_PUSH;
                end
            end
            RD_PUSH: begin
                if (byte_cnt_q == 9'd511) begin
                    state_d = DONE;
                end else begin
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = sector_addr(drv_q, c_q, h_q, r_q, byte_cnt_q + 9'd1);
                    state_d    = RD_REQ;
                end
            end
            // The FDC FIFO write lands one cycle after the request, hence the gap.
            WR_GAP: begin
                clkout_d = 1'b1;
                state_d  = WR_PULL;
            end
            WR_PULL: begin
                mem_wdata_d = disk_data_out;
                mem_wr_d    = 1'b1;
                mem_addr_d  = sector_addr(drv_q, c_q, h_q, r_q, byte_cnt_q);
                state_d     = WR_REQ;
            end
            WR_REQ: begin
                if (mem.mem_ack) begin
                    mem_wr_d = 1'b0;
                    if (byte_cnt_q == 9'd511) begin
                        state_d = DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 9'd1;
                        clkout_d   = 1'b1;
                        state_d    = WR_PULL;
                    end
                end
            end
            DONE: begin
                cr_done_d = 1'b1;
                cr_err_d  = 1'b0;
                cr_h_d    = {7'd0, h_q};
                cr_r_d    = r_q;
                state_d   = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (disk_sr[16] && held_req == 2'b00) begin
                    cr_done_d = 1'b0;
                    cr_err_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drv_q       <= 1'b0;
            c_q         <= 7'd0;
            h_q         <= 1'b0;
            r_q         <= 8'd0;
            op_q        <= OP_RID;
            rid_cnt_q   <= 8'd0;
            byte_cnt_q  <= 9'd0;
            seek_done_q <= 2'b00;
            cr_err_q    <= 1'b0;
            cr_done_q   <= 1'b0;
            cr_h_q      <= 8'd0;
            cr_r_q      <= 8'd0;
            data_in_q   <= 8'd0;
            mem_wdata_q <= 8'd0;
            clkin_q     <= 1'b0;
            clkout_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            drv_q       <= drv_d;
            c_q         <= c_d;
            h_q         <= h_d;
            r_q         <= r_d;
            op_q        <= op_d;
            rid_cnt_q   <= rid_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            seek_done_q <= seek_done_d;
            cr_err_q    <= cr_err_d;
            cr_done_q   <= cr_done_d;
            cr_h_q      <= cr_h_d;
            cr_r_q      <= cr_r_d;
            data_in_q   <= data_in_d;
            mem_wdata_q <= mem_wdata_d;
            clkin_q     <= clkin_d;
            clkout_q    <= clkout_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign disk_cr = {cr_r_q, 8'd0, cr_h_q, 1'b0, img_mounted, cr_done_q, cr_err_q, 1'b0, seek_done_q};
    assign disk_data_in     = data_in_q;
    assign disk_data_clkin  = clkin_q;
    assign disk_data_clkout = clkout_q;
    assign mem.mem_addr     = mem_addr_q;
    assign mem.mem_rd       = mem_rd_q;
    assign mem.mem_wr       = mem_wr_q;
    assign mem.mem_wdata    = mem_wdata_q;
endmodule

// File: tb/tb_fdc_disk_responder.sv
// Bench for fdc_disk_responder: image-store and FDC FIFO models plus directed
// operations with randomized sectors, data and ack latency.
module tb_fdc_disk_responder;
    localparam int IMG_BYTES = 2 * 40 * 2 * 9 * 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] disk_sr;
    logic [31:0] disk_cr;
    logic [7:0]  disk_data_in;
    logic        disk_data_clkin;
    logic [7:0]  disk_data_out;
    logic        disk_data_clkout;
    logic [1:0]  img_mounted;
    logic [1:0]  img_wp;

    fdc_disk_responder_if #(.ADDR_W(24)) mem_if ();

    fdc_disk_responder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .disk_sr          (disk_sr),
        .disk_cr          (disk_cr),
        .disk_data_in     (disk_data_in),
        .disk_data_clkin  (disk_data_clkin),
        .disk_data_out    (disk_data_out),
        .disk_data_clkout (disk_data_clkout),
        .img_mounted      (img_mounted),
        .img_wp           (img_wp),
        .mem              (mem_if.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] image [IMG_BYTES];
    logic [7:0] fifo  [512];
    int         wait_cnt = 0;
    int         ack_lat  = 0;
    int         fixed_lat = -1;
    int         fifo_ptr = 0;
    int         pops = 0;
    int         back2back = 0;
    logic       clkin_prev = 1'b0;
    int         rd_addr_log[$];
    int         wr_addr_log[$];
    logic [7:0] wr_data_log[$];
    logic [7:0] push_log[$];
    int         rid_model;

    // Backing store: acks after ack_lat waiting cycles (0 = same cycle as request).
    assign mem_if.mem_ack   = (mem_if.mem_rd || mem_if.mem_wr) && (wait_cnt >= ack_lat);
    assign mem_if.mem_rdata = (int'(mem_if.mem_addr) < IMG_BYTES) ? image[mem_if.mem_addr] : 8'h00;
    assign disk_data_out    = fifo[fifo_ptr[8:0]];

    always @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (mem_if.mem_ack) begin
            wait_cnt <= 0;
            ack_lat  <= (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            if (mem_if.mem_wr) begin
                image[mem_if.mem_addr] <= mem_if.mem_wdata;
                wr_addr_log.push_back(int'(mem_if.mem_addr));
                wr_data_log.push_back(mem_if.mem_wdata);
            end else begin
                rd_addr_log.push_back(int'(mem_if.mem_addr));
            end
        end else if (mem_if.mem_rd || mem_if.mem_wr) begin
            wait_cnt <= wait_cnt + 1;
        end
        if (disk_data_clkin) push_log.push_back(disk_data_in);
        if (disk_data_clkin && clkin_prev) back2back <= back2back + 1;
        clkin_prev <= disk_data_clkin;
        if (disk_data_clkout) begin
            pops     <= pops + 1;
            fifo_ptr <= fifo_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_sr(input int bitpos, input int c, input int h, input int r);
        logic [31:0] v;
        v         = 32'd0;
        v[bitpos] = 1'b1;
        v[14:8]   = 7'(c);
        v[15]     = 1'(h);
        v[7:0]    = 8'(r);
        return v;
    endfunction

    function automatic int exp_base(input int d, input int c, input int h, input int r);
        return (((d * 40 + c) * 2 + h) * 9 + (r - 'hC1)) * 512;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (disk_cr[4] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(disk_cr[4]), 32'd1);
    endtask

    task automatic release_done(input string tag);
        int n;
        n = 0;
        disk_sr = 32'h0001_0000;
        @(negedge clk);
        while (disk_cr[4] !== 1'b0 && n < 4) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(disk_cr[4:0]), 32'd0);
        disk_sr = 32'd0;
        @(negedge clk);
    endtask

    task automatic do_read(input int d, input int c, input int h, input int r, input bit withdraw);
        int base, dmis, amis;
        base = exp_base(d, c, h, r);
        rd_addr_log.delete();
        push_log.delete();
        back2back = 0;
        disk_sr = mk_sr(17 + d, c, h, r);
        @(negedge clk);
        check("rd_first_req", 32'(mem_if.mem_rd), 32'd1);
        if (withdraw) disk_sr = 32'd0;
        wait_done("rd_done", 8000);
        check("rd_err", 32'(disk_cr[3]), 32'd0);
        check("rd_pushes", push_log.size(), 512);
        check("rd_reqs", rd_addr_log.size(), 512);
        dmis = 0;
        amis = 0;
        for (int k = 0; k < 512 && k < push_log.size(); k++)
            if (push_log[k] !== image[base + k]) dmis++;
        for (int k = 0; k < 512 && k < rd_addr_log.size(); k++)
            if (rd_addr_log[k] != base + k) amis++;
        check("rd_data", dmis, 0);
        check("rd_addr", amis, 0);
        check("rd_clkin_gap", back2back, 0);
        check("rd_R", 32'(disk_cr[31:24]), r);
        check("rd_H", 32'(disk_cr[15:8]), h);
        repeat (3) @(negedge clk);
        check("rd_hold", 32'(disk_cr[4]), 32'd1);
        $display("read  d=%0d c=%0d h=%0d r=%0h base=%0d bytes=%0d", d, c, h, r, base, push_log.size());
        release_done("rd_release");
    endtask

    task automatic do_write(input int d, input int c, input int h, input int r);
        int base, dmis, amis;
        base = exp_base(d, c, h, r);
        for (int k = 0; k < 512; k++) fifo[k] = 8'($urandom);
        fifo_ptr = 0;
        pops = 0;
        wr_addr_log.delete();
        wr_data_log.delete();
        disk_sr = mk_sr(20 + d, c, h, r);
        @(negedge clk);
        check("wr_pop_n1", 32'(disk_data_clkout), 32'd0);
        @(negedge clk);
        check("wr_pop_n2", 32'(disk_data_clkout), 32'd1);
        wait_done("wr_done", 8000);
        check("wr_err", 32'(disk_cr[3]), 32'd0);
        check("wr_pops", pops, 512);
        check("wr_reqs", wr_addr_log.size(), 512);
        dmis = 0;
        amis = 0;
        for (int k = 0; k < 512 && k < wr_addr_log.size(); k++) begin
            if (wr_addr_log[k] != base + k) amis++;
            if (wr_data_log[k] !== fifo[k]) dmis++;
        end
        check("wr_addr", amis, 0);
        check("wr_data", dmis, 0);
        check("wr_R", 32'(disk_cr[31:24]), r);
        $display("write d=%0d c=%0d h=%0d r=%0h base=%0d pops=%0d", d, c, h, r, base, pops);
        release_done("wr_release");
    endtask

    task automatic do_err(input string tag, input logic [31:0] sr);
        int p0;
        p0 = pops;
        rd_addr_log.delete();
        wr_addr_log.delete();
        disk_sr = sr;
        @(negedge clk);
        check({tag, "_done"}, 32'(disk_cr[4]), 32'd1);
        check({tag, "_err"}, 32'(disk_cr[3]), 32'd1);
        check({tag, "_memreq"}, 32'({mem_if.mem_rd, mem_if.mem_wr}), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_nomem"}, rd_addr_log.size() + wr_addr_log.size(), 0);
        check({tag, "_nopop"}, pops - p0, 0);
        $display("error op %s sr=%08h cr=%08h", tag, sr, disk_cr);
        release_done({tag, "_release"});
    endtask

    initial begin
        int d, c, h, r;
        for (int k = 0; k < IMG_BYTES; k++) image[k] = 8'(k);
        for (int k = 0; k < 512; k++) fifo[k] = 8'd0;
        rst_n = 1'b0;
        disk_sr = 32'd0;
        img_mounted = 2'b11;
        img_wp = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_cr", disk_cr, 32'h0000_0060);
        check("rst_strobes", 32'({disk_data_clkin, disk_data_clkout}), 32'd0);
        check("rst_mem", 32'({mem_if.mem_rd, mem_if.mem_wr}), 32'd0);
        check("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Seek drive A to C=5, then out-of-range seek to C=40.
        disk_sr = mk_sr(24, 5, 0, 0);
        @(negedge clk);
        check("seek_a", 32'(disk_cr[4:0]), 32'h01);
        repeat (3) @(negedge clk);
        check("seek_hold", 32'(disk_cr[4:0]), 32'h01);
        disk_sr = 32'd0;
        @(negedge clk);
        check("seek_clr", 32'(disk_cr[4:0]), 32'h00);
        $display("seek  d=0 c=5 ok");
        disk_sr = mk_sr(24, 40, 0, 0);
        @(negedge clk);
        check("seek_range", 32'(disk_cr[4:0]), 32'h09);
        disk_sr = 32'd0;
        @(negedge clk);
        check("seek_range_clr", 32'(disk_cr[4:0]), 32'h00);
        $display("seek  d=0 c=40 error");

        do_read(1, 2, 0, 'hC3, 1'b0);

        // Reset in the middle of a read, then a normal (withdrawn) read.
        disk_sr = mk_sr(17, 1, 1, 'hC5);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        disk_sr = 32'd0;
        @(negedge clk);
        check("midrst_mem", 32'({mem_if.mem_rd, mem_if.mem_wr}), 32'd0);
        check("midrst_strobes", 32'({disk_data_clkin, disk_data_clkout}), 32'd0);
        check("midrst_cr", 32'(disk_cr[4:0]), 32'd0);
        rst_n = 1'b1;
        rid_model = 0;
        @(negedge clk);
        $display("reset during read");
        d = int'($urandom_range(0, 1));
        c = int'($urandom_range(0, 39));
        h = int'($urandom_range(0, 1));
        r = 'hC1 + int'($urandom_range(0, 8));
        do_read(d, c, h, r, 1'b1);

        for (int i = 0; i < 10; i++) begin
            h = int'($urandom_range(0, 1));
            disk_sr = mk_sr(22, 0, h, 0);
            @(negedge clk);
            check("rid_done", 32'(disk_cr[4:3]), 32'h2);
            check("rid_R", 32'(disk_cr[31:24]), 'hC1 + rid_model);
            check("rid_H", 32'(disk_cr[15:8]), h);
            $display("rid   n=%0d h=%0d R=%02h", i, h, disk_cr[31:24]);
            rid_model = (rid_model + 1) % 9;
            release_done("rid_release");
        end

        fixed_lat = 3;
        ack_lat = 3;
        do_write(0, 0, 1, 'hC1);
        fixed_lat = -1;
        d = int'($urandom_range(0, 1));
        c = int'($urandom_range(0, 39));
        h = int'($urandom_range(0, 1));
        r = 'hC1 + int'($urandom_range(0, 8));
        do_write(d, c, h, r);
        do_read(d, c, h, r, 1'b0);

        img_wp = 2'b01;
        do_err("wp", mk_sr(20, 3, 0, 'hC2));
        img_wp = 2'b00;
        do_err("range_r", mk_sr(17, 3, 0, 'hCA));
        do_err("range_c", mk_sr(18, 40, 1, 'hC1));
        img_mounted = 2'b01;
        @(negedge clk);
        check("mounted_bits", 32'(disk_cr[6:5]), 32'h1);
        do_err("unmounted", mk_sr(18, 3, 0, 'hC1));
        img_mounted = 2'b11;

        // Seek and read together: seek must be serviced first.
        rd_addr_log.delete();
        disk_sr = mk_sr(24, 3, 0, 0) | mk_sr(17, 3, 0, 'hC1);
        @(negedge clk);
        check("prio_seek", 32'(disk_cr[4:0]), 32'h01);
        check("prio_no_rd", 32'(mem_if.mem_rd), 32'd0);
        disk_sr = 32'd0;
        @(negedge clk);
        check("prio_clr", 32'(disk_cr[4:0]), 32'h00);
        check("prio_nomem", rd_addr_log.size(), 0);
        $display("priority seek over read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
